// File: rtl/serial_frame_tx.sv
// serial_frame_tx: latches a DATA_W-bit word on an accepted start and shifts it
// out on tx_data, holding each bit for CLK_DIV clk cycles, with tx_valid high for
// every bit slot. done pulses for one cycle after a normal frame completes.
// abort cancels a frame in flight. rst is asynchronous and active high.
//
// Optional feature: define SERIAL_FRAME_TX_PARITY_EN to append an even-parity
// bit (XOR of the latched word) after the data bits, held for CLK_DIV cycles.
//
// state  | meaning
// IDLE   | waiting for start; ready=1
// SHIFT  | data bits going out, one per CLK_DIV cycles
// PARITY | parity bit slot (SERIAL_FRAME_TX_PARITY_EN builds only)
module serial_frame_tx #(
  parameter int DATA_W    = 4,
  parameter int CLK_DIV   = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              tx_valid,
  output logic              tx_data,
  output logic              done
);

  localparam int              BW       = $clog2(DATA_W + 1);
  localparam logic [7:0]      DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SERIAL_FRAME_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] sreg_next;
  logic [7:0]        div_cnt;
  logic [BW-1:0]     bit_cnt;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              par;
`endif

  // The bit on the wire is always the leading end of the shift register.
  function automatic logic lead_bit(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return w[DATA_W-1];
    else                return w[0];
  endfunction

  // Shift register contents after moving on to the next bit.
  always_comb begin
    sreg_next = sreg;
    if (MSB_FIRST != 0) sreg_next = {sreg[DATA_W-2:0], 1'b0};
    else                sreg_next = {1'b0, sreg[DATA_W-1:1]};
  end

  // Frame FSM with registered outputs; abort takes priority over everything in a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      ready    <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= 1'b0;
      done     <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            sreg     <= data_in;
            tx_data  <= lead_bit(data_in);
            tx_valid <= 1'b1;
            ready    <= 1'b0;
            div_cnt  <= DIV_LOAD;
            bit_cnt  <= BW'(1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par      <= ^data_in;
`endif
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end else if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state   <= PARITY;
            tx_data <= par;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
`else
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b1;
            bit_cnt  <= '0;
`endif
          end else begin
            sreg    <= sreg_next;
            tx_data <= lead_bit(sreg_next);
            bit_cnt <= bit_cnt + 1'b1;
            div_cnt <= DIV_LOAD;
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY: begin
          if (abort) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            div_cnt  <= '0;
          end else if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b1;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          tx_data  <= 1'b0;
          ready    <= 1'b1;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: a 4-bit/div-1/LSB-first instance and an
// 8-bit/div-3/MSB-first instance share clock and reset.
module tb_serial_frame_tx;

  logic       clk;
  logic       rst;
  logic       start0, abort0;
  logic [3:0] data0;
  logic       ready0, tx_valid0, tx_data0, done0;
  logic       start1, abort1;
  logic [7:0] data1;
  logic       ready1, tx_valid1, tx_data1, done1;

  int n_checks = 0;
  int n_pass   = 0;

  serial_frame_tx #(.DATA_W(4), .CLK_DIV(1), .MSB_FIRST(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .data_in(data0),
    .ready(ready0), .tx_valid(tx_valid0), .tx_data(tx_data0), .done(done0)
  );

  serial_frame_tx #(.DATA_W(8), .CLK_DIV(3), .MSB_FIRST(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .data_in(data1),
    .ready(ready1), .tx_valid(tx_valid1), .tx_data(tx_data1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Entered at the negedge right after the accepting edge; leaves at the done-cycle negedge.
  // A start pulse with junk data is injected mid-frame and must be ignored.
  task automatic expect_frame0(input logic [3:0] d, input logic [3:0] junk);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("f0 valid b%0d", i), 32'(tx_valid0), 32'd1);
      check_val($sformatf("f0 data b%0d", i), 32'(tx_data0), 32'(d[i]));
      check_val($sformatf("f0 ready b%0d", i), 32'(ready0), 32'd0);
      if (i == 0) begin start0 = 1'b0; data0 = junk; end
      if (i == 1) start0 = 1'b1;
      if (i == 2) start0 = 1'b0;
      @(negedge clk);
    end
`ifdef SERIAL_FRAME_TX_PARITY_EN
    check_val("f0 parity valid", 32'(tx_valid0), 32'd1);
    check_val("f0 parity bit", 32'(tx_data0), 32'(^d));
    @(negedge clk);
`endif
  endtask

  task automatic done_cycle0(input string tag);
    check_val({tag, " done"}, 32'(done0), 32'd1);
    check_val({tag, " ready"}, 32'(ready0), 32'd1);
    check_val({tag, " valid"}, 32'(tx_valid0), 32'd0);
    check_val({tag, " data"}, 32'(tx_data0), 32'd0);
  endtask

  initial begin
    logic [7:0] seq;
    logic       seen_done;
    rst = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; data0 = 4'h0;
    start1 = 1'b0; abort1 = 1'b0; data1 = 8'h00;

    // Reset values appear with no clock edge yet.
    #3;
    check_val("rst ready0", 32'(ready0), 32'd1);
    check_val("rst valid0", 32'(tx_valid0), 32'd0);
    check_val("rst data0", 32'(tx_data0), 32'd0);
    check_val("rst done0", 32'(done0), 32'd0);
    check_val("rst ready1", 32'(ready1), 32'd1);
    check_val("rst valid1", 32'(tx_valid1), 32'd0);

    // Start on the first edge after reset release: 1011 -> 1,1,0,1.
    @(negedge clk);
    rst = 1'b0; start0 = 1'b1; data0 = 4'b1011;
    @(negedge clk);
    expect_frame0(4'b1011, 4'b0000);
    done_cycle0("f1");
    // Back-to-back start held in the done cycle.
    start0 = 1'b1; data0 = 4'b0110;
    @(negedge clk);
    expect_frame0(4'b0110, 4'b1111);
    done_cycle0("f2");
    @(negedge clk);
    check_val("no queued start done", 32'(done0), 32'd0);
    check_val("no queued start ready", 32'(ready0), 32'd1);
    check_val("no queued start valid", 32'(tx_valid0), 32'd0);

    // 0111: parity bit 1 when parity is built in.
    start0 = 1'b1; data0 = 4'b0111;
    @(negedge clk);
    expect_frame0(4'b0111, 4'b1000);
    done_cycle0("f3");
    @(negedge clk);

    // start and abort together in IDLE: abort wins.
    start0 = 1'b1; abort0 = 1'b1; data0 = 4'b1111;
    @(negedge clk);
    check_val("idle abort valid", 32'(tx_valid0), 32'd0);
    check_val("idle abort ready", 32'(ready0), 32'd1);
    check_val("idle abort done", 32'(done0), 32'd0);
    start0 = 1'b0; abort0 = 1'b0;

    // 8'hA5 MSB first, 3 cycles per bit.
    start1 = 1'b1; data1 = 8'hA5;
    @(negedge clk);
    start1 = 1'b0; data1 = 8'h00;
    seq = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        check_val($sformatf("a5 valid b%0d c%0d", i, k), 32'(tx_valid1), 32'd1);
        check_val($sformatf("a5 data b%0d c%0d", i, k), 32'(tx_data1), 32'(seq[7-i]));
        check_val($sformatf("a5 ready b%0d c%0d", i, k), 32'(ready1), 32'd0);
        @(negedge clk);
      end
    end
`ifdef SERIAL_FRAME_TX_PARITY_EN
    for (int k = 0; k < 3; k++) begin
      check_val("a5 parity valid", 32'(tx_valid1), 32'd1);
      check_val("a5 parity bit", 32'(tx_data1), 32'd0);
      @(negedge clk);
    end
`endif
    check_val("a5 done", 32'(done1), 32'd1);
    check_val("a5 end valid", 32'(tx_valid1), 32'd0);
    check_val("a5 end ready", 32'(ready1), 32'd1);
    @(negedge clk);

    // Abort at the third bit of 8'h3C (MSB first: 0,0,1,...).
    start1 = 1'b1; data1 = 8'h3C;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check_val($sformatf("ab valid c%0d", c), 32'(tx_valid1), 32'd1);
      @(negedge clk);
    end
    check_val("ab third bit", 32'(tx_data1), 32'd1);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    check_val("ab valid", 32'(tx_valid1), 32'd0);
    check_val("ab ready", 32'(ready1), 32'd1);
    check_val("ab done", 32'(done1), 32'd0);
    check_val("ab data", 32'(tx_data1), 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      seen_done = seen_done | done1;
      @(negedge clk);
    end
    check_val("ab no late done", 32'(seen_done), 32'd0);

    // Asynchronous reset mid-frame, then a clean 4'h3 frame.
    start0 = 1'b1; data0 = 4'b1111;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    check_val("pre-rst valid", 32'(tx_valid0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async rst ready", 32'(ready0), 32'd1);
    check_val("async rst valid", 32'(tx_valid0), 32'd0);
    check_val("async rst data", 32'(tx_data0), 32'd0);
    check_val("async rst done", 32'(done0), 32'd0);
    @(negedge clk);
    rst = 1'b0; start0 = 1'b1; data0 = 4'h3;
    @(negedge clk);
    expect_frame0(4'h3, 4'h0);
    done_cycle0("f4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
